alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command sequencer around an external combinational ALU.
// Holds a 4-entry register file, launches one operation at a time to the
// ALU, captures its result and flags, and returns a response through a
// valid/ready handshake. Loads of immediates bypass the ALU.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs,
  input  logic [1:0]       cmd_rt,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_co,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] regs [4];
  logic [1:0]       rd_q;
  logic             accept;
  logic             rsp_done;

  assign accept   = (state == IDLE) && cmd_valid;
  assign rsp_done = (state == RESP) && rsp_ready;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: loads skip EXEC, ALU ops spend exactly one cycle there.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = cmd_load ? RESP : EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the current state.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture for the ALU; held until the next ALU command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_ctr <= 3'b000;
      rd_q    <= 2'd0;
    end else if (accept && !cmd_load) begin
      alu_a   <= regs[cmd_rs];
      alu_b   <= regs[cmd_rt];
      alu_ctr <= cmd_op;
      rd_q    <= cmd_rd;
    end
  end

  // Register file writes: immediate on load accept, ALU result at end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (accept && cmd_load) begin
      regs[cmd_rd] <= cmd_imm;
    end else if (state == EXEC) begin
      regs[rd_q] <= alu_res;
    end
  end

  // Response payload; flags are taken from the ALU exactly as presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_flags <= 3'b000;
    end else if (accept && cmd_load) begin
      rsp_data  <= cmd_imm;
      rsp_flags <= 3'b000;
    end else if (state == EXEC) begin
      rsp_data  <= alu_res;
      rsp_flags <= {alu_co, alu_zero, alu_ovf};
    end
  end

  // Completed-response counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        op_count <= 8'h00;
    else if (rsp_done) op_count <= op_count + 8'h01;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus randomized bench for alu_sequencer with a
// behavioural ALU and a register-file/counter reference model.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_rd;
  logic [1:0]  cmd_rs;
  logic [1:0]  cmd_rt;
  logic [31:0] cmd_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_res;
  logic        alu_co;
  logic        alu_zero;
  logic        alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic [7:0]  op_count;

  int          tests;
  int          fails;
  logic [31:0] model_regs [4];
  logic [7:0]  model_count;
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [2:0]  last_ctr;
  logic [31:0] last_data;
  logic [2:0]  last_flags;

  alu_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctr   (alu_ctr),
    .alu_res   (alu_res),
    .alu_co    (alu_co),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {result, co, zero, ovf}.
  function automatic logic [34:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        co;
    logic        ovf;
    wide = 33'd0;
    co   = 1'b0;
    ovf  = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[31:0];
        co   = wide[32];
        ovf  = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd3: r = a ^ b;
      3'd4: r = ~(a | b);
      3'd5: r = ~(a & b);
      3'd6: begin
        wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r    = wide[31:0];
        co   = wide[32];
        ovf  = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    return {r, co, (r == 32'd0), ovf};
  endfunction

  // External ALU is purely combinational from the sequencer's operand outputs.
  always_comb begin
    {alu_res, alu_co, alu_zero, alu_ovf} = alu_fn(alu_ctr, alu_a, alu_b);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'd0;
    model_count = 8'h00;
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_ctr", 32'(alu_ctr), 32'd0);
    checkOutput("rst_data", rsp_data, 32'd0);
    checkOutput("rst_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete command: accept, optional EXEC, RESP held `delay` cycles, handshake.
  task automatic applyStimulus(input logic load, input logic [2:0] op, input logic [1:0] rd,
                               input logic [1:0] rs, input logic [1:0] rt,
                               input logic [31:0] imm, input int delay);
    logic [31:0] a;
    logic [31:0] b;
    logic [34:0] res;
    logic [31:0] exp_data;
    logic [2:0]  exp_flags;
    @(negedge clk);
    checkOutput("idle_ready", 32'(cmd_ready), 32'd1);
    cmd_load  = load;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!load) begin
      a   = model_regs[rs];
      b   = model_regs[rt];
      res = alu_fn(op, a, b);
      exp_data  = res[34:3];
      exp_flags = res[2:0];
      checkOutput("exec_a", alu_a, a);
      checkOutput("exec_b", alu_b, b);
      checkOutput("exec_ctr", 32'(alu_ctr), 32'(op));
      checkOutput("exec_no_valid", 32'(rsp_valid), 32'd0);
      checkOutput("exec_not_ready", 32'(cmd_ready), 32'd0);
      last_a   = alu_a;
      last_b   = alu_b;
      last_ctr = alu_ctr;
      @(posedge clk);
      #1;
      checkOutput("resp_a_stable", alu_a, a);
      checkOutput("resp_ctr_stable", 32'(alu_ctr), 32'(op));
    end else begin
      exp_data  = imm;
      exp_flags = 3'b000;
    end
    checkOutput("resp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("resp_data", rsp_data, exp_data);
    checkOutput("resp_flags", 32'(rsp_flags), 32'(exp_flags));
    last_data  = rsp_data;
    last_flags = rsp_flags;
    model_regs[rd] = exp_data;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_data", rsp_data, exp_data);
      checkOutput("hold_count", 32'(op_count), 32'(model_count));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready   = 1'b0;
    model_count = model_count + 8'h01;
    checkOutput("done_count", 32'(op_count), 32'(model_count));
    checkOutput("done_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = 3'd0;
    cmd_rd    = 2'd0;
    cmd_rs    = 2'd0;
    cmd_rt    = 2'd0;
    cmd_imm   = 32'd0;
    rsp_ready = 1'b0;
    doReset();

    // Loads then ADD r3 = r1 + r2.
    applyStimulus(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 32'd5, 0);
    applyStimulus(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 32'd3, 1);
    applyStimulus(1'b0, 3'd2, 2'd3, 2'd1, 2'd2, 32'd0, 0);
    checkOutput("add_ctr", 32'(last_ctr), 32'd2);
    checkOutput("add_a", last_a, 32'd5);
    checkOutput("add_b", last_b, 32'd3);
    checkOutput("add_data", last_data, 32'd8);
    checkOutput("add_co_zero", 32'(last_flags[2:1]), 32'd0);

    // SUB r0 = r2 - r1 = 3 - 5.
    applyStimulus(1'b0, 3'd6, 2'd0, 2'd2, 2'd1, 32'd0, 0);
    checkOutput("sub_ctr", 32'(last_ctr), 32'd6);
    checkOutput("sub_data", last_data, 32'hFFFFFFFE);
    checkOutput("sub_flags", 32'(last_flags), 32'd0);

    // r3 must now read back as 8.
    applyStimulus(1'b0, 3'd1, 2'd1, 2'd3, 2'd3, 32'd0, 0);
    checkOutput("r3_readback", last_data, 32'd8);

    // Response stall with a competing command offered the whole time.
    @(negedge clk);
    cmd_load  = 1'b1;
    cmd_rd    = 2'd0;
    cmd_imm   = 32'h00001234;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    model_regs[0] = 32'h00001234;
    cmd_rd  = 2'd2;
    cmd_imm = 32'hAAAA5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_data", rsp_data, 32'h00001234);
      checkOutput("stall_ready", 32'(cmd_ready), 32'd0);
      checkOutput("stall_count", 32'(op_count), 32'(model_count));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready   = 1'b0;
    model_count = model_count + 8'h01;
    checkOutput("hs_count", 32'(op_count), 32'(model_count));
    checkOutput("hs_not_accepted", 32'(rsp_valid), 32'd0);
    checkOutput("hs_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    model_regs[2] = 32'hAAAA5555;
    checkOutput("late_valid", 32'(rsp_valid), 32'd1);
    checkOutput("late_data", rsp_data, 32'hAAAA5555);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready   = 1'b0;
    model_count = model_count + 8'h01;
    checkOutput("late_count", 32'(op_count), 32'(model_count));

    // Reset during EXEC of ADD r3 = r1 + r2 abandons the operation.
    @(negedge clk);
    cmd_load  = 1'b0;
    cmd_op    = 3'd2;
    cmd_rd    = 2'd3;
    cmd_rs    = 2'd1;
    cmd_rt    = 2'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("abort_exec_ctr", 32'(alu_ctr), 32'd2);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'd0;
    model_count = 8'h00;
    checkOutput("abort_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_alu_a", alu_a, 32'd0);
    checkOutput("abort_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
    applyStimulus(1'b0, 3'd2, 2'd0, 2'd3, 2'd3, 32'd0, 0);
    checkOutput("abort_r3_zero", last_data, 32'd0);
    checkOutput("abort_zero_flag", 32'(last_flags), 32'b010);

    // Back-to-back: load r1 = 7, then ADD r1 = r1 + r1.
    applyStimulus(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 32'd7, 0);
    applyStimulus(1'b0, 3'd2, 2'd1, 2'd1, 2'd1, 32'd0, 0);
    checkOutput("b2b_a", last_a, 32'd7);
    checkOutput("b2b_b", last_b, 32'd7);
    checkOutput("b2b_data", last_data, 32'd14);

    // Randomized mix of loads and all ALU ops against the model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] imm;
      imm = $urandom;
      if ($urandom_range(0, 3) == 0) imm = 32'h80000000 | (imm & 32'h7);
      applyStimulus(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    imm, int'($urandom_range(0, 2)));
    end

    // 257 loads from a fresh reset: counter wraps to 1.
    doReset();
    for (int n = 0; n < 257; n++) begin
      applyStimulus(1'b1, 3'd0, 2'($urandom_range(0, 3)), 2'd0, 2'd0, $urandom, 0);
    end
    checkOutput("wrap_count", 32'(op_count), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
